// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle: BCD word and display controls in, pin-level drive out.
interface seg7_scan_if;
   import seg7_pkg::*;

   logic                  en;
   logic [15:0]           bcd_in;
   logic [NUM_DIGITS-1:0] dp_sel;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;
   logic                  dp;
   logic                  frame_start;

   modport master (
      output en, bcd_in, dp_sel, blank_lz,
      input  an, seg, dp, frame_start
   );

   modport slave (
      input  en, bcd_in, dp_sel, blank_lz,
      output an, seg, dp, frame_start
   );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit common-anode driver with per-frame shadow latching,
// leading-zero blanking, decimal point and a one-cycle anti-ghosting slot.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100_000
)(
   input  logic        clk,
   input  logic        rst,
   seg7_scan_if.slave  bus
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0]      cnt_reg;
   digit_idx_t            idx_reg;
   digit_idx_t            idx_next;
   logic                  tick;
   logic                  prime_reg;
   logic                  load;
   logic                  load_d1_reg;

   logic [15:0]           bcd_sh_reg,  bcd_sh_next;
   logic [NUM_DIGITS-1:0] dp_sh_reg,   dp_sh_next;
   logic                  blz_sh_reg,  blz_sh_next;

   logic [NUM_DIGITS-1:1] zero_vec;
   logic [NUM_DIGITS-1:0] blank_vec;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;
   logic [6:0]            seg_next;

   logic [NUM_DIGITS-1:0] an_reg;
   logic [6:0]            seg_reg;
   logic                  dp_reg;
   logic                  frame_start_reg;

   assign tick     = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
   assign idx_next = tick ? digit_idx_t'(idx_reg + 2'd1) : idx_reg;
   assign load     = prime_reg | (tick & (idx_reg == 2'd3));

   assign bcd_sh_next = load ? bus.bcd_in   : bcd_sh_reg;
   assign dp_sh_next  = load ? bus.dp_sel   : dp_sh_reg;
   assign blz_sh_next = load ? bus.blank_lz : blz_sh_reg;

   // A digit blanks only if it and every more-significant digit are zero with no dp.
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
         assign zero_vec[gi]  = (bcd_sh_next[gi*4 +: 4] == 4'd0) & ~dp_sh_next[gi];
         assign blank_vec[gi] = blz_sh_next & (&zero_vec[NUM_DIGITS-1:gi]);
      end
   endgenerate
   assign blank_vec[0] = 1'b0;

   // Decode the digit that will be shown after this edge, so seg leads an by the ghost slot.
   assign nibble   = bcd_sh_next[{idx_next, 2'b00} +: 4];
   assign seg_next = blank_vec[idx_next] ? SEG_BLANK : seg_dec;

   bcd_to_seg7 u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg         <= '0;
         idx_reg         <= '0;
         prime_reg       <= 1'b1;
         load_d1_reg     <= 1'b0;
         bcd_sh_reg      <= '0;
         dp_sh_reg       <= '0;
         blz_sh_reg      <= 1'b0;
         an_reg          <= '1;
         seg_reg         <= SEG_BLANK;
         dp_reg          <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         cnt_reg         <= tick ? '0 : cnt_reg + 1'b1;
         idx_reg         <= idx_next;
         prime_reg       <= 1'b0;
         load_d1_reg     <= load;
         frame_start_reg <= load_d1_reg;
         bcd_sh_reg      <= bcd_sh_next;
         dp_sh_reg       <= dp_sh_next;
         blz_sh_reg      <= blz_sh_next;
         // Outputs stay dark until the primed shadow is in place.
         if (!prime_reg) begin
            an_reg  <= (tick || !bus.en) ? '1 : ~(NUM_DIGITS'(1) << idx_reg);
            seg_reg <= seg_next;
            dp_reg  <= ~dp_sh_next[idx_next];
         end
      end
   end

   assign bus.an          = an_reg;
   assign bus.seg         = seg_reg;
   assign bus.dp          = dp_reg;
   assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at REFRESH_DIV=4: reset, scan order, blanking,
// decimal point, frame coherence, enable gating and mid-scan reset.
module tb_seg7_scan;
   import seg7_pkg::*;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   seg7_scan_if bus ();

   seg7_scan #(.REFRESH_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Return at the first lit cycle of digit d (the cycle right after its ghost slot).
   task automatic wait_slot(input int d);
      logic [3:0] prev;
      logic [3:0] want;
      bit         found;
      want  = ~(4'b0001 << d);
      prev  = bus.an;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (prev == 4'hF && bus.an == want) found = 1'b1;
         else prev = bus.an;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL slot_timeout digit %0d: an=%h, expected %h within 64 cycles", d, bus.an, want);
      end
   endtask

   // Return on a frame_start that belongs to a load taken after the caller's last input change.
   task automatic wait_frame();
      bit found;
      found = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (bus.frame_start === 1'b1) found = 1'b1;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL frame_timeout: frame_start=%b, expected 1 within 64 cycles", bus.frame_start);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b1;
      bus.bcd_in = 16'h1234;
      bus.dp_sel = 4'b0000;
      bus.blank_lz = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c == 3) begin
            @(posedge clk);
            #1 rst = 1'b0;
         end
         @(negedge clk);
         n_tests++;
         if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values cycle %0d: an=%h seg=%h dp=%b fs=%b, expected an=f seg=7f dp=1 fs=0",
                     c, bus.an, bus.seg, bus.dp, bus.frame_start);
         end
         $display("[TB] reset cycle %0d an=%h seg=%h dp=%b fs=%b", c, bus.an, bus.seg, bus.dp, bus.frame_start);
      end
      @(negedge clk);
      n_tests++;
      if (bus.an !== 4'hE || bus.seg !== 7'h19 || bus.frame_start !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_digit: an=%h seg=%h fs=%b, expected an=e seg=19 fs=1",
                  bus.an, bus.seg, bus.frame_start);
      end
      $display("[TB] first digit after reset an=%h seg=%h fs=%b", bus.an, bus.seg, bus.frame_start);
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg [4];
      int         order [4];
      exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
      order   = '{1, 2, 3, 0};
      for (int k = 0; k < 4; k++) begin
         int         d;
         logic [3:0] an_on;
         d     = order[k];
         an_on = ~(4'b0001 << d);
         wait_slot(d);
         n_tests++;
         if (bus.seg !== exp_seg[d] || bus.dp !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_seg digit %0d: seg=%h dp=%b, expected seg=%h dp=1", d, bus.seg, bus.dp, exp_seg[d]);
         end
         $display("[TB] scan digit %0d an=%h seg=%h", d, bus.an, bus.seg);
         for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            n_tests++;
            if (bus.an !== an_on) begin
               n_fail++;
               $display("FAIL scan_hold digit %0d: an=%h, expected %h", d, bus.an, an_on);
            end
         end
         @(negedge clk);
         n_tests++;
         if (bus.an !== 4'hF || bus.seg !== exp_seg[(d + 1) % 4]) begin
            n_fail++;
            $display("FAIL scan_ghost after digit %0d: an=%h seg=%h, expected an=f seg=%h",
                     d, bus.an, bus.seg, exp_seg[(d + 1) % 4]);
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [6:0] upper_exp [2];
      upper_exp = '{7'h7F, 7'h40};
      bus.bcd_in = 16'h0007;
      bus.dp_sel = 4'b0000;
      for (int pass = 0; pass < 2; pass++) begin
         bus.blank_lz = (pass == 0);
         wait_frame();
         for (int d = 1; d < 4; d++) begin
            wait_slot(d);
            n_tests++;
            if (bus.seg !== upper_exp[pass]) begin
               n_fail++;
               $display("FAIL lz_upper blank_lz=%0d digit %0d: seg=%h, expected %h", 1 - pass, d, bus.seg, upper_exp[pass]);
            end
            $display("[TB] lz blank_lz=%0d digit %0d seg=%h", 1 - pass, d, bus.seg);
         end
         wait_slot(0);
         n_tests++;
         if (bus.seg !== 7'h78) begin
            n_fail++;
            $display("FAIL lz_ones blank_lz=%0d: seg=%h, expected 78", 1 - pass, bus.seg);
         end
      end
   endtask

   task automatic test_decimal_point();
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      int         order   [4];
      exp_seg = '{7'h40, 7'h12, 7'h40, 7'h7F};
      exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
      order   = '{1, 2, 3, 0};
      bus.bcd_in   = 16'h0050;
      bus.dp_sel   = 4'b0100;
      bus.blank_lz = 1'b1;
      wait_frame();
      for (int k = 0; k < 4; k++) begin
         int d;
         d = order[k];
         wait_slot(d);
         n_tests++;
         if (bus.seg !== exp_seg[d] || bus.dp !== exp_dp[d]) begin
            n_fail++;
            $display("FAIL dp_digit %0d: seg=%h dp=%b, expected seg=%h dp=%b", d, bus.seg, bus.dp, exp_seg[d], exp_dp[d]);
         end
         $display("[TB] dp digit %0d seg=%h dp=%b", d, bus.seg, bus.dp);
      end
   endtask

   task automatic test_frame_coherence();
      logic [6:0] old_seg [4];
      logic [6:0] new_seg [4];
      old_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
      new_seg = '{7'h40, 7'h40, 7'h3F, 7'h10};
      bus.bcd_in   = 16'h1234;
      bus.dp_sel   = 4'b0000;
      bus.blank_lz = 1'b0;
      wait_frame();
      wait_slot(1);
      bus.bcd_in = 16'h9A00;
      for (int d = 1; d < 4; d++) begin
         if (d > 1) wait_slot(d);
         n_tests++;
         if (bus.seg !== old_seg[d]) begin
            n_fail++;
            $display("FAIL coherence_old digit %0d: seg=%h, expected %h", d, bus.seg, old_seg[d]);
         end
         $display("[TB] coherence old frame digit %0d seg=%h", d, bus.seg);
      end
      wait_slot(0);
      n_tests++;
      if (bus.frame_start !== 1'b1 || bus.seg !== new_seg[0]) begin
         n_fail++;
         $display("FAIL coherence_new_frame: fs=%b seg=%h, expected fs=1 seg=%h", bus.frame_start, bus.seg, new_seg[0]);
      end
      for (int d = 1; d < 4; d++) begin
         wait_slot(d);
         n_tests++;
         if (bus.seg !== new_seg[d]) begin
            n_fail++;
            $display("FAIL coherence_new digit %0d: seg=%h, expected %h", d, bus.seg, new_seg[d]);
         end
         $display("[TB] coherence new frame digit %0d seg=%h", d, bus.seg);
      end
   endtask

   task automatic test_enable();
      wait_slot(1);
      bus.en = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         n_tests++;
         if (bus.an !== 4'hF) begin
            n_fail++;
            $display("FAIL en_off cycle %0d: an=%h, expected f", c, bus.an);
         end
      end
      n_tests++;
      if (bus.seg !== 7'h10) begin
         n_fail++;
         $display("FAIL en_idx_advance: seg=%h, expected 10 (digit 3)", bus.seg);
      end
      $display("[TB] en=0 for 10 cycles, now seg=%h", bus.seg);
      bus.en = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.an !== 4'hF || bus.seg !== 7'h40) begin
         n_fail++;
         $display("FAIL en_reenable_ghost: an=%h seg=%h, expected an=f seg=40", bus.an, bus.seg);
      end
      @(negedge clk);
      n_tests++;
      if (bus.an !== 4'hE) begin
         n_fail++;
         $display("FAIL en_reenable_digit0: an=%h, expected e", bus.an);
      end
      $display("[TB] re-enabled an=%h seg=%h", bus.an, bus.seg);
   endtask

   task automatic test_mid_reset();
      wait_slot(2);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_values: an=%h seg=%h dp=%b fs=%b, expected an=f seg=7f dp=1 fs=0",
                  bus.an, bus.seg, bus.dp, bus.frame_start);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
         n_fail++;
         $display("FAIL midrst_release: an=%h seg=%h, expected an=f seg=7f", bus.an, bus.seg);
      end
      @(negedge clk);
      n_tests++;
      if (bus.an !== 4'hE || bus.seg !== 7'h40 || bus.frame_start !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_restart: an=%h seg=%h fs=%b, expected an=e seg=40 fs=1", bus.an, bus.seg, bus.frame_start);
      end
      $display("[TB] scan restarted an=%h seg=%h", bus.an, bus.seg);
      wait_slot(2);
      n_tests++;
      if (bus.seg !== 7'h3F) begin
         n_fail++;
         $display("FAIL midrst_digit2: seg=%h, expected 3f", bus.seg);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_leading_zero();
      test_decimal_point();
      test_frame_coherence();
      test_enable();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for a 4-digit common-anode 7-segment display. Consumes the 16-bit packed 8421 BCD word from the binary-to-BCD converter and scans one digit per refresh period. Latches the BCD word once per frame so displayed digits never tear. Applies leading-zero blanking, a decimal point, and an anti-ghosting blank slot. Sits between the binary-to-BCD stage and the board pins.

## Interface
- REFRESH_DIV, default 100_000: clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range ≥ 2.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; 0 forces all anodes off.
- bcd_in  in  16  {thousands, hundreds, tens, ones}, 4 bits each.
- dp_sel  in  4  one-hot decimal-point digit select (bit i = digit i, digit 0 = ones).
- blank_lz  in  1  leading-zero blanking enable.
- an  out  4  digit anodes, active-low (an[i] drives digit i).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when the shadow registers load.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. `tick` asserts on count == REFRESH_DIV-1.
- Digit index idx (2 bits) advances 0→1→2→3→0 on each tick.
- Shadow load: bcd_in, dp_sel and blank_lz are captured into shadow registers on a tick with idx==3, i.e. on entry to digit 0. A prime flag set by reset forces one load on the first cycle after rst deasserts. frame_start pulses on the cycle after each load.
- Blanking flags use shadow nibbles N3..N0 and the shadow dp_sel D:
  - blank3 = blank_lz & N3==0 & !D[3]
  - blank2 = blank3 & N2==0 & !D[2]
  - blank1 = blank2 & N1==0 & !D[1]
  - Digit 0 is never blanked.
- Decode, active-low:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Nibble ≥ 4'hA shows '-' = 7'h3F.
  - Blanked digit = 7'h7F.
- dp = ~D[idx]. dp_sel is not checked for one-hot; the selected bit is used as-is.
- en=0: an held 4'hF. Prescaler, idx and shadow loads keep running, so re-enable is phase-continuous.

## Timing
- Reset values, held during rst and on the first cycle after release: an=4'hF, seg=7'h7F, dp=1, frame_start=0, prescaler=0, idx=0, shadow=0, prime=1.
- All outputs are registered; no combinational path from inputs to pins.
- Digit change, with tick at cycle T:
  - T+1: an=4'hF (ghost slot); seg and dp already show the new digit.
  - T+2 through the next tick: an = ~(1<<idx) if en, otherwise 4'hF.
- After reset release, digit 0 is driven with the primed shadow at cycle 2.
- Input changes mid-frame are invisible until the next idx 3→0 tick. Latency from input to pins is at most 4·REFRESH_DIV+2 cycles.
- rst mid-scan: everything returns to reset values on the next edge, and the prime reload follows.
- en toggling takes effect on an one cycle later.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS=4
  - typedef digit_idx_t (logic [1:0])
  - active-low segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
- Sub-module bcd_to_seg7: purely combinational nibble → 7-bit active-low pattern. Instantiated once on the idx-muxed nibble.
- Top module holds the prescaler, idx counter, shadow/prime logic, blanking and output registers.

## Test plan
Sims use REFRESH_DIV=4.
- Reset: hold rst 3 cycles with bcd_in=16'h1234. Expect an=4'hF, seg=7'h7F, dp=1, frame_start=0 throughout and one cycle after release.
- Scan: bcd_in=16'h1234, blank_lz=0, dp_sel=0, en=1. Expect an/seg pairs 4'hE/7'h19, 4'hD/7'h30, 4'hB/7'h24, 4'h7/7'h79. Each pair is preceded by one an=4'hF cycle and lasts 3 cycles.
- Leading zeros: bcd_in=16'h0007, blank_lz=1. Digits 3..1 show seg=7'h7F and digit 0 shows seg=7'h78. With blank_lz=0, digits 3..1 show 7'h40.
- Decimal point: bcd_in=16'h0050, dp_sel=4'b0100, blank_lz=1. Expect:
  - digit 3: 7'h7F
  - digit 2: 7'h40 with dp=0
  - digit 1: 7'h12
  - digit 0: 7'h40
  - dp=1 on every digit except digit 2
- Frame coherence and invalid input:
  - Change bcd_in from 16'h1234 to 16'h9A00 while idx=1. Digits 1–3 still show 3,2,1.
  - After the next frame_start, digits show 0,0,'-'(7'h3F),9 (7'h10).
- en and mid-scan reset:
  - en=0 for 10 cycles: an=4'hF, and idx keeps advancing.
  - Assert rst at idx=2: reset values on the next edge, then a scan restarting at digit 0.
